// File: rtl/stw_counter.sv
// Stopwatch timekeeping datapath: divides CLK down to a centisecond tick and
// advances a BCD MM:SS.cc count while enabled, with synchronous clear.
module stw_counter #(
    parameter int unsigned TICK_DIV = 10000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STW_ON,
    input  logic       STW_RST_N,
    output logic [3:0] CS_L,
    output logic [3:0] CS_H,
    output logic [3:0] SEC_L,
    output logic [3:0] SEC_H,
    output logic [3:0] MIN_L,
    output logic [3:0] MIN_H,
    output logic       TICK,
    output logic       OVF
);

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    logic [15:0] pre;
    logic        tc;
    logic        cs_l_max, cs_h_max, sec_l_max, sec_h_max, min_l_max, min_h_max;
    logic        c_cs_h, c_sec_l, c_sec_h, c_min_l, c_min_h, c_wrap;

    assign tc        = (pre == PRE_LAST) & STW_ON & STW_RST_N;
    assign cs_l_max  = (CS_L  == 4'd9);
    assign cs_h_max  = (CS_H  == 4'd9);
    assign sec_l_max = (SEC_L == 4'd9);
    assign sec_h_max = (SEC_H == 4'd5);
    assign min_l_max = (MIN_L == 4'd9);
    assign min_h_max = (MIN_H == 4'd5);

    // Each carry means every lower digit is at its maximum on a tick edge.
    assign c_cs_h  = tc      & cs_l_max;
    assign c_sec_l = c_cs_h  & cs_h_max;
    assign c_sec_h = c_sec_l & sec_l_max;
    assign c_min_l = c_sec_h & sec_h_max;
    assign c_min_h = c_min_l & min_l_max;
    assign c_wrap  = c_min_h & min_h_max;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre   <= '0;
            CS_L  <= '0;
            CS_H  <= '0;
            SEC_L <= '0;
            SEC_H <= '0;
            MIN_L <= '0;
            MIN_H <= '0;
            TICK  <= 1'b0;
            OVF   <= 1'b0;
        end else if (!STW_RST_N) begin
            // Clear beats a coincident tick, including the full wrap.
            pre   <= '0;
            CS_L  <= '0;
            CS_H  <= '0;
            SEC_L <= '0;
            SEC_H <= '0;
            MIN_L <= '0;
            MIN_H <= '0;
            TICK  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            TICK <= tc;
            OVF  <= c_wrap;
            if (tc) begin
                pre <= '0;
            end else if (STW_ON) begin
                pre <= pre + 16'd1;
            end
            if (tc)      CS_L  <= cs_l_max  ? 4'd0 : CS_L  + 4'd1;
            if (c_cs_h)  CS_H  <= cs_h_max  ? 4'd0 : CS_H  + 4'd1;
            if (c_sec_l) SEC_L <= sec_l_max ? 4'd0 : SEC_L + 4'd1;
            if (c_sec_h) SEC_H <= sec_h_max ? 4'd0 : SEC_H + 4'd1;
            if (c_min_l) MIN_L <= min_l_max ? 4'd0 : MIN_L + 4'd1;
            if (c_min_h) MIN_H <= min_h_max ? 4'd0 : MIN_H + 4'd1;
        end
    end

endmodule

// File: tb/tb_stw_counter.sv
// Bench for stw_counter: directed scenarios plus randomized run/pause/clear,
// checked against an elapsed-centisecond model of the stopwatch.
module tb_stw_counter;

    localparam int TD    = 4;
    localparam int SPAN  = 360000;   // centiseconds in 60 minutes

    logic       clk;
    logic       rst;
    logic       stw_on;
    logic       stw_rst_n;
    logic [3:0] cs_l, cs_h, sec_l, sec_h, min_l, min_h;
    logic       tick, ovf;
    logic [23:0] obs_disp;

    int n_checks = 0;
    int n_errors = 0;

    stw_counter #(.TICK_DIV(TD)) dut (
        .CLK(clk), .RST(rst), .STW_ON(stw_on), .STW_RST_N(stw_rst_n),
        .CS_L(cs_l), .CS_H(cs_h), .SEC_L(sec_l), .SEC_H(sec_h),
        .MIN_L(min_l), .MIN_H(min_h), .TICK(tick), .OVF(ovf)
    );

    assign obs_disp = {min_h, min_l, sec_h, sec_l, cs_h, cs_l};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: elapsed time as a plain count of centiseconds.
    function automatic logic [23:0] to_disp(input int t);
        int cs, s, m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = t / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    int   m_total    = 0;
    int   m_phase    = 0;   // clock cycles into the current centisecond
    logic m_tick     = 1'b0;
    logic m_ovf      = 1'b0;
    logic m_load     = 1'b0;
    int   m_load_val = 0;
    logic chk_en     = 1'b1;
    logic [23:0] exp_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst || !stw_rst_n) begin
            m_total <= 0;
            m_phase <= 0;
            m_tick  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_tick <= 1'b0;
            m_ovf  <= 1'b0;
            if (m_load) begin
                m_total <= m_load_val;
            end else if (stw_on) begin
                if (m_phase + 1 == TD) begin
                    m_phase <= 0;
                    m_total <= (m_total + 1) % SPAN;
                    m_tick  <= 1'b1;
                    m_ovf   <= ((m_total + 1) % SPAN) == 0;
                    exp_q.push_back(to_disp((m_total + 1) % SPAN));
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
        end
    end

    // scoreboard: per-cycle comparison plus tick-value queue
    always @(negedge clk) begin
        logic [23:0] exp_val;
        if (chk_en)
            check("cycle", {6'b0, tick, ovf, obs_disp}, {6'b0, m_tick, m_ovf, to_disp(m_total)});
        if (tick) begin
            check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                if (chk_en) check("tick_value", 32'(obs_disp), 32'(exp_val));
            end
        end
    end

    // driver tasks
    task automatic run(input logic on, input logic rn, input int n);
        stw_on    = on;
        stw_rst_n = rn;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_count(input logic on, input logic rn, input int n, output int ticks);
        stw_on    = on;
        stw_rst_n = rn;
        ticks     = 0;
        repeat (n) begin
            @(negedge clk);
            if (tick) ticks++;
        end
    endtask

    initial begin
        int t1, t2, t3, nt;
        rst       = 1'b0;
        stw_on    = 1'b0;
        stw_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {6'b0, tick, ovf, obs_disp}, 32'd0);
        rst = 1'b1;

        // asynchronous reset mid-count at 00:03.47
        run(1'b1, 1'b1, 347 * TD);
        check("pre_reset_count", obs_disp, 32'h000347);
        run(1'b1, 1'b1, 2);
        stw_on = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_async_digits", obs_disp, 32'd0);
        check("rst_async_flags", {tick, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_hold", {tick, ovf, obs_disp}, 32'd0);
        end

        // basic run: ten ticks exactly TD apart
        run(1'b0, 1'b0, 1);
        stw_on    = 1'b1;
        stw_rst_n = 1'b1;
        nt = 0;
        for (int i = 1; i <= 10 * TD; i++) begin
            @(negedge clk);
            check("basic_tick_spacing", tick, 32'((i % TD) == 0));
            if (tick) nt++;
        end
        check("basic_tick_count", nt, 32'd10);
        check("basic_count", obs_disp, 32'h000010);

        // pause / resume keeps the partial centisecond
        run(1'b0, 1'b0, 1);
        run_count(1'b1, 1'b1, 6, t1);
        run_count(1'b0, 1'b1, 20, t2);
        check("pause_no_tick", t2, 32'd0);
        run_count(1'b1, 1'b1, 2, t3);
        check("pause_total_ticks", t1 + t3, 32'd2);
        check("pause_count", obs_disp, 32'h000002);
        check("resume_tick_edge", tick, 32'd1);

        // carry chain 00:59.99 -> 01:00.00
        run(1'b0, 1'b0, 1);
        run(1'b1, 1'b1, 5999 * TD);
        check("carry_pre", obs_disp, 32'h005999);
        run(1'b1, 1'b1, TD);
        check("carry_digits", obs_disp, 32'h010000);
        check("carry_ovf", ovf, 32'd0);
        check("carry_tick", tick, 32'd1);

        // wrap: seconds/minutes preset to 59:59, centiseconds run naturally
        stw_on = 1'b0;
        chk_en = 1'b0;
        force dut.SEC_H = 4'd5;
        force dut.SEC_L = 4'd9;
        force dut.MIN_H = 4'd5;
        force dut.MIN_L = 4'd9;
        m_load_val = 359900;
        m_load     = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        chk_en = 1'b1;
        run(1'b1, 1'b1, 99 * TD);
        check("wrap_pre", obs_disp, 32'h595999);
        chk_en = 1'b0;
        run(1'b1, 1'b1, TD);
        check("wrap_tick", tick, 32'd1);
        check("wrap_ovf", ovf, 32'd1);
        check("wrap_cs", obs_disp[7:0], 32'd0);
        stw_on = 1'b0;
        force dut.SEC_H = 4'd0;
        force dut.SEC_L = 4'd0;
        force dut.MIN_H = 4'd0;
        force dut.MIN_L = 4'd0;
        release dut.SEC_H;
        release dut.SEC_L;
        release dut.MIN_H;
        release dut.MIN_L;
        chk_en = 1'b1;
        @(negedge clk);
        check("wrap_ovf_one_cycle", {tick, ovf}, 32'd0);
        run(1'b1, 1'b1, TD);
        check("wrap_next", obs_disp, 32'h000001);
        check("wrap_next_ovf", ovf, 32'd0);

        // clear priority at 00:12.99 with the prescaler on its last count
        run(1'b0, 1'b0, 1);
        run(1'b1, 1'b1, 1299 * TD + TD - 1);
        check("clr_pre", obs_disp, 32'h001299);
        run(1'b1, 1'b0, 1);
        check("clr_digits", obs_disp, 32'd0);
        check("clr_tick", {tick, ovf}, 32'd0);
        stw_on    = 1'b1;
        stw_rst_n = 1'b1;
        for (int i = 1; i <= TD; i++) begin
            @(negedge clk);
            check("clr_first_tick", tick, 32'(i == TD));
        end

        // randomized run / pause / clear against the model
        for (int i = 0; i < 3000; i++) begin
            stw_on    = ($urandom_range(0, 9) != 0);
            stw_rst_n = ($urandom_range(0, 79) != 0);
            @(negedge clk);
        end
        run(1'b0, 1'b1, 2);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stw_counter.md
# stw_counter

Stopwatch timekeeping datapath that consumes the run/clear control pair produced by the stopwatch control logic (STW_ON, STW_RST_N). It divides the system clock down to a 100 Hz centisecond tick and, while enabled, advances a BCD count of minutes, seconds and centiseconds (MM:SS.cc) for the display multiplexer. It sits between the stopwatch control block and the 7-segment display path.

## Interface

- TICK_DIV, default 10000: CLK cycles per centisecond (CLK frequency / 100); legal range 2..65535.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- STW_ON  input  1  run enable from the stopwatch control block; level, synchronous to CLK.
- STW_RST_N  input  1  synchronous active-low clear from the stopwatch control block; level.
- CS_L  output  4  centiseconds ones digit, BCD 0..9.
- CS_H  output  4  centiseconds tens digit, BCD 0..9.
- SEC_L  output  4  seconds ones digit, BCD 0..9.
- SEC_H  output  4  seconds tens digit, BCD 0..5.
- MIN_L  output  4  minutes ones digit, BCD 0..9.
- MIN_H  output  4  minutes tens digit, BCD 0..5.
- TICK  output  1  one-cycle pulse on each centisecond advance.
- OVF  output  1  one-cycle pulse when the count wraps 59:59.99 -> 00:00.00.

## Operation

- Prescaler: 16-bit counter PRE, counts 0..TICK_DIV-1. Increments only when STW_ON=1 and STW_RST_N=1. The terminal condition TC = (PRE == TICK_DIV-1) & STW_ON & STW_RST_N. On TC, PRE returns to 0.
- Pause: STW_ON=0 freezes PRE and all digits; the partial centisecond is retained, so resuming loses no time.
- Clear: STW_RST_N=0 forces PRE and all six digits to 0 on the next edge, regardless of STW_ON. Clear has priority over counting. While STW_RST_N stays low, everything holds at 0, and TICK and OVF stay 0.
- Digit chain, ripple-carry in BCD, evaluated in one cycle on TC:
  - CS_L 9->0 carries into CS_H.
  - CS_H 9->0 carries into SEC_L.
  - SEC_L 9->0 carries into SEC_H.
  - SEC_H 5->0 carries into MIN_L.
  - MIN_L 9->0 carries into MIN_H.
  - MIN_H 5->0 is the full wrap.
  - A digit changes only when all lower digits are at their maximum and TC=1.
- Wrap: at 59:59.99 a TC sets all digits to 0 and asserts OVF for that cycle. Counting continues; there is no saturation.
- Digits never hold non-BCD values. SEC_H and MIN_H never exceed 5.

## Timing

- Reset (RST=0, asynchronous): PRE=0, all digits 0, TICK=0, OVF=0. These take effect immediately and are held while RST is low. Release is synchronous: the first possible increment is the first edge after RST rises.
- Latency:
  - Digits, TICK and OVF are registered.
  - They update on the same edge at which PRE wraps from TICK_DIV-1 to 0.
  - TICK and OVF are high for exactly the following cycle.
- Run rate: with STW_ON held high, one centisecond every TICK_DIV cycles. The first TICK comes TICK_DIV edges after STW_ON is first sampled high from a cleared state.
- STW_ON falling on the cycle where PRE == TICK_DIV-1: no advance occurs, and PRE stays at TICK_DIV-1. The next cycle sampled with STW_ON=1 produces the advance.
- STW_RST_N low on a TC cycle: the clear wins. Digits go to 0, TICK=0 and OVF=0 (this applies also at 59:59.99).
- Clear latency is 1 cycle. After STW_RST_N returns high with STW_ON=1, the first TICK comes TICK_DIV cycles later.
- Inputs are synchronous to CLK; no internal synchronizers are provided.

## Test plan

- Reset: assert RST=0 mid-count at 00:03.47 -> all outputs are 0 immediately (asynchronous), and remain 0 through 5 edges after RST=1 with STW_ON=0.
- Basic run (TICK_DIV=4): STW_ON=1 for 40 cycles from clear -> 10 TICK pulses spaced exactly 4 cycles apart; final count is 00:00.10 (CS_H=1, CS_L=0).
- Pause/resume (TICK_DIV=4): run 6 cycles, drop STW_ON for 20 cycles, resume for 2 cycles -> exactly 2 TICKs in total, count is 00:00.02, and there is no TICK during the pause.
- Carry chain: preload 00:59.99 by running, then apply one TC -> 01:00.00 on one edge (SEC_H=0, MIN_L=1), and OVF=0.
- Wrap: reach 59:59.99, then apply one TC -> all digits 0, OVF=1 and TICK=1 for exactly one cycle; on the next TC, 00:00.01 with OVF=0.
- Clear priority: at 00:12.99 with PRE=TICK_DIV-1 and STW_ON=1, assert STW_RST_N=0 for one cycle -> next edge shows 00:00.00 with TICK=0. After release, the first TICK comes TICK_DIV cycles later.
